idct_dequant_loader: RTL and testbench
======================================

Name: idct_dequant_loader

Overview:
- Upstream feeder of the fully pipelined IDCT core, which takes 64x12-bit signed coefficients in parallel, has no handshake, and has a latency of 26 stages.
- Accepts a serial coefficient stream in zigzag order over valid/ready and dequantizes each coefficient with a writable 64-entry quant table.
- Scatters coefficients into natural (row-major) order and zero-fills after an end-of-block marker.
- Presents each completed block as one registered 768-bit word, held stable until the next block completes, so it can drive the IDCT x input directly.

Parameters:
- WIN, 12, output coefficient width (must match IDCT input width).
- WCOEF, 12, input coefficient width (signed).
- WQ, 8, quant table entry width (unsigned).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- s_valid  in  1  coefficient valid.
- s_ready  out  1  loader can accept a coefficient.
- s_coef  in  WCOEF  signed coefficient, zigzag order.
- s_last  in  1  end of block; remaining positions are zero.
- q_we  in  1  quant table write enable.
- q_addr  in  6  quant table index (natural order).
- q_data  in  WQ  quant table value.
- out_block  out  64*WIN  dequantized block; element n at bits [n*WIN +: WIN], natural order.
- out_valid  out  1  one-cycle pulse when out_block updates.
- blk_count  out  16  number of blocks emitted, wrapping.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Values on reset:
  - out_block = 0, out_valid = 0, blk_count = 0.
  - Zigzag counter k = 0; accumulation buffer = 0; pipeline valid = 0.
  - Quant table = all 1 (dequant is identity after reset).
- Reset mid-block discards all partial data and pending pipeline entries.
- Handshake:
  - Accept when s_valid && s_ready.
  - s_ready = !rst && !q_we, so table writes take priority and stall the stream for that cycle.
  - A table write becomes visible to coefficients accepted in the following cycle or later.
- Stage 1 (accept cycle):
  - Natural index n = ZIGZAG[k].
  - prod = s_coef * q_table[n], signed x unsigned, computed in WCOEF+WQ+1 bits.
  - Register prod, n, and blk_end = s_last || (k == 63).
  - k increments; k resets to 0 when blk_end.
- Stage 2 (cycle after accept):
  - Saturate prod to WIN signed, range [-2048, 2047], and write buffer[n].
  - If blk_end: out_block <= buffer with the write applied, out_valid <= 1, blk_count += 1 (wraps at 2^16), and the buffer clears to 0.
- Latency: out_valid is high in the second cycle after the final coefficient is accepted. out_block then holds until the next block completes.
- Back-to-back blocks: the first coefficient of the next block may be accepted the cycle after blk_end. Its stage-2 write lands in the freshly cleared buffer, so no bubble is required.
- Boundary cases:
  - s_last on k = 0: block is DC only; all other entries are 0.
  - s_last on k = 63: identical to a natural end of block.
  - s_valid low between coefficients: stalls are allowed mid-block, and k holds.
  - s_coef ignored when not accepted.
- Duplicate positions cannot occur: the counter is monotonic within a block.

Decomposition:
- Shared package idct_pkg:
  - WIN and WOUT constants.
  - Typedef coef_t (signed WIN).
  - 64-entry ZIGZAG constant array (zigzag index -> natural index).
  - Function sat_coef(prod) -> coef_t.
- Sub-module idct_quant_ram: 64xWQ register file with synchronous write (q_we/q_addr/q_data) and an asynchronous read port. Its reset initializes all entries to 1.

Test Plan:
- DC/EOB vector:
  - Setup: table all 1. Stream -166,-7,-2,-2,0,-4,-4 with s_last on the 7th.
  - Expect: out_block n0=-166, n1=-7, n8=-2, n16=-2, n2=-4, n3=-4, all else 0; out_valid exactly 2 cycles after the last accept.
  - Chain into IDCT: output after 26 more cycles begins -24,-23,-21.
- Full zigzag, no s_last:
  - Setup: table all 1. Stream s_coef = k for k = 0..63.
  - Expect: out_block[ZIGZAG[k]] == k for all k; blk_count = 1.
- Dequant and saturation:
  - Setup: q[0]=16, q[1]=255.
  - Stream 100 (-> 1600) then -2048 (-> -2048*255 saturates to -2048), then s_last.
  - Also: 2047 * q = 2 -> 2047.
- Back-to-back with stalls:
  - Two 64-coefficient blocks with no gap, then a third with random s_valid gaps.
  - Expect: three out_valid pulses, no leakage of block 1 into block 2, blk_count = 3.
- Table write priority:
  - Assert q_we (addr 0, data 4) concurrently with s_valid: s_ready = 0 that cycle.
  - Coefficient 10 accepted next cycle at k=0 -> out n0 = 40.
- Reset mid-block:
  - Accept 20 coefficients, pulse rst, then stream a DC-only block of 5.
  - Expect: out_block n0=5 and all else 0; blk_count = 1; no out_valid during or after rst until the new block completes.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants, coefficient type, zigzag scan table and the saturation
// helper used by the dequantizing loader in front of the IDCT core.
package idct_pkg;

   localparam int WIN   = 12;
   localparam int WOUT  = 9;
   localparam int WCOEF = 12;
   localparam int WQ    = 8;
   localparam int WP    = WCOEF + WQ + 1;
   localparam int NCOEF = 64;

   typedef logic signed [WIN-1:0] coef_t;

   // zigzag scan position -> natural (row-major) position
   localparam logic [5:0] ZIGZAG [NCOEF] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   localparam logic signed [WP-1:0] PROD_MAX = WP'((1 << (WIN-1)) - 1);
   localparam logic signed [WP-1:0] PROD_MIN = WP'(-(1 << (WIN-1)));
   localparam coef_t COEF_MAX = {1'b0, {(WIN-1){1'b1}}};
   localparam coef_t COEF_MIN = {1'b1, {(WIN-1){1'b0}}};

   // clamp a full-width dequantized product into the IDCT input range
   function automatic coef_t sat_coef(input logic signed [WP-1:0] prod);
      if (prod > PROD_MAX)
         return COEF_MAX;
      else if (prod < PROD_MIN)
         return COEF_MIN;
      else
         return prod[WIN-1:0];
   endfunction

endpackage

// File: rtl/idct_quant_ram.sv
// 64-entry quantization table: synchronous write, asynchronous read.
// Reset loads every entry with 1 so dequantization starts as identity.
module idct_quant_ram
   import idct_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          q_we,
   input  logic [5:0]    q_addr,
   input  logic [WQ-1:0] q_data,
   input  logic [5:0]    rd_addr,
   output logic [WQ-1:0] rd_data
);

   logic [WQ-1:0] mem [NCOEF];

   // table update; reset restores identity scaling
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCOEF; i++)
            mem[i] <= WQ'(1);
      end else if (q_we) begin
         mem[q_addr] <= q_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/idct_dequant_loader.sv
// Serial zigzag coefficient stream -> dequantized, saturated, natural-order
// 64-coefficient block presented as one registered word for the IDCT core.
// Stage 1 (accept): zigzag lookup and multiply. Stage 2: saturate, scatter
// into the accumulation buffer and, on end of block, publish the block.
module idct_dequant_loader
   import idct_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic signed [WCOEF-1:0] s_coef,
   input  logic                    s_last,
   input  logic                    q_we,
   input  logic [5:0]              q_addr,
   input  logic [WQ-1:0]           q_data,
   output logic [NCOEF*WIN-1:0]    out_block,
   output logic                    out_valid,
   output logic [15:0]             blk_count
);

   logic [5:0]             k;
   logic [5:0]             n_acc;
   logic [WQ-1:0]          q_val;
   logic                   accept;
   logic                   blk_end_acc;
   logic signed [WP-1:0]   coef_ext;
   logic signed [WP-1:0]   q_ext;
   logic signed [WP-1:0]   prod;

   logic                   p1_valid;
   logic signed [WP-1:0]   p1_prod;
   logic [5:0]             p1_n;
   logic                   p1_end;

   logic [NCOEF*WIN-1:0]   buffer;
   logic [NCOEF*WIN-1:0]   buf_wr;

   // table writes own the cycle, so the stream stalls while one is pending
   assign s_ready     = !rst && !q_we;
   assign accept      = s_valid && s_ready;
   assign n_acc       = ZIGZAG[k];
   assign blk_end_acc = s_last || (k == 6'd63);

   idct_quant_ram u_qram (
      .clk     (clk),
      .rst     (rst),
      .q_we    (q_we),
      .q_addr  (q_addr),
      .q_data  (q_data),
      .rd_addr (n_acc),
      .rd_data (q_val)
   );

   // signed coefficient times unsigned quant value, wide enough to never wrap
   assign coef_ext = WP'(s_coef);
   assign q_ext    = WP'(q_val);
   assign prod     = coef_ext * q_ext;

   // stage 1: capture product, target position and end-of-block; advance k
   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         p1_valid <= 1'b0;
         p1_prod  <= '0;
         p1_n     <= '0;
         p1_end   <= 1'b0;
      end else begin
         p1_valid <= accept;
         if (accept) begin
            p1_prod <= prod;
            p1_n    <= n_acc;
            p1_end  <= blk_end_acc;
            k       <= blk_end_acc ? 6'd0 : k + 6'd1;
         end
      end
   end

   // buffer contents with the current stage-2 write folded in
   always_comb begin
      buf_wr = buffer;
      if (p1_valid)
         buf_wr[p1_n*WIN +: WIN] = sat_coef(p1_prod);
   end

   // stage 2: scatter into buffer; on end of block publish it and start clean
   always_ff @(posedge clk) begin
      if (rst) begin
         buffer    <= '0;
         out_block <= '0;
         out_valid <= 1'b0;
         blk_count <= '0;
      end else begin
         out_valid <= 1'b0;
         if (p1_valid) begin
            if (p1_end) begin
               out_block <= buf_wr;
               buffer    <= '0;
               out_valid <= 1'b1;
               blk_count <= blk_count + 16'd1;
            end else begin
               buffer <= buf_wr;
            end
         end
      end
   end

endmodule

// File: tb/tb_idct_dequant_loader.sv
// Directed bench for idct_dequant_loader. Inputs change on the falling edge,
// outputs are observed on the falling edge (plus #1), away from the rising edge.
module tb_idct_dequant_loader;

   logic               clk = 1'b0;
   logic               rst;
   logic               s_valid;
   logic               s_ready;
   logic signed [11:0] s_coef;
   logic               s_last;
   logic               q_we;
   logic [5:0]         q_addr;
   logic [7:0]         q_data;
   logic [767:0]       out_block;
   logic               out_valid;
   logic [15:0]        blk_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   int pulses = 0;
   int pulse_cyc = 0;
   logic [767:0] blk_q [$];

   int zz [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   idct_dequant_loader dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_coef    (s_coef),
      .s_last    (s_last),
      .q_we      (q_we),
      .q_addr    (q_addr),
      .q_data    (q_data),
      .out_block (out_block),
      .out_valid (out_valid),
      .blk_count (blk_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (out_valid) begin
         pulses++;
         pulse_cyc = cyc;
         blk_q.push_back(out_block);
      end
   end

   function automatic int el(input logic [767:0] b, input int n);
      logic signed [11:0] v;
      v = b[n*12 +: 12];
      return int'(v);
   endfunction

   task automatic send(input int c, input logic l);
      logic rdy;
      int   t = 0;
      s_valid = 1'b1;
      s_coef  = c[11:0];
      s_last  = l;
      forever begin
         #1 rdy = s_ready;
         @(posedge clk);
         @(negedge clk);
         if (rdy) break;
         t++;
         if (t > 20) begin
            total++; bad++;
            $display("FAIL send_stall: coefficient %0d never accepted", c);
            break;
         end
      end
      acc_cyc = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_coef  = 12'sh5a5;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         s_coef = 12'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic q_write(input int a, input int d);
      q_we   = 1'b1;
      q_addr = a[5:0];
      q_data = d[7:0];
      @(negedge clk);
      q_we   = 1'b0;
   endtask

   task automatic wait_pulses(input int target);
      int t = 0;
      #1;
      while (pulses < target && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      total++;
      if (pulses != target) begin
         bad++;
         $display("FAIL pulse_count: got %0d pulses, need %0d", pulses, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_coef = '0; s_last = 1'b0;
      q_we = 1'b0; q_addr = '0; q_data = '0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b need 0", s_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
      total++;
      if (blk_count !== 16'd0) begin bad++; $display("FAIL rst_blk_count: got %0d need 0", blk_count); end
      total++;
      if (out_block !== '0) begin bad++; $display("FAIL rst_out_block: got %h need 0", out_block); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %b need 1", s_ready); end
      @(negedge clk);
   endtask

   task automatic test_dc_eob();
      int exp [64];
      int vals [7] = '{-166, -7, -2, -2, 0, -4, -4};
      logic [767:0] b;
      for (int n = 0; n < 64; n++) exp[n] = 0;
      exp[0] = -166; exp[1] = -7; exp[8] = -2; exp[16] = -2; exp[2] = -4; exp[3] = -4;
      blk_q.delete();
      for (int i = 0; i < 7; i++) send(vals[i], i == 6);
      wait_pulses(1);
      // accept edge registers stage 1, the following edge raises out_valid
      total++;
      if (pulse_cyc - acc_cyc != 1) begin
         bad++; $display("FAIL dc_latency: got %0d edges need 1", pulse_cyc - acc_cyc);
      end
      b = (blk_q.size() > 0) ? blk_q[0] : '0;
      for (int n = 0; n < 64; n++) begin
         total++;
         if (el(b, n) != exp[n]) begin
            bad++; $display("FAIL dc_elem[%0d]: got %0d need %0d", n, el(b, n), exp[n]);
         end
      end
      total++;
      if (blk_count !== 16'd1) begin bad++; $display("FAIL dc_blk_count: got %0d need 1", blk_count); end
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL dc_pulse_width: got %b need 0", out_valid); end
      total++;
      if (el(out_block, 0) != -166) begin bad++; $display("FAIL dc_hold: got %0d need -166", el(out_block, 0)); end
   endtask

   task automatic test_full_zigzag();
      int exp [64];
      logic [767:0] b;
      for (int k = 0; k < 64; k++) exp[zz[k]] = k;
      blk_q.delete();
      for (int k = 0; k < 64; k++) send(k, 1'b0);
      wait_pulses(2);
      b = (blk_q.size() > 0) ? blk_q[0] : '0;
      for (int n = 0; n < 64; n++) begin
         total++;
         if (el(b, n) != exp[n]) begin
            bad++; $display("FAIL zz_elem[%0d]: got %0d need %0d", n, el(b, n), exp[n]);
         end
      end
      total++;
      if (blk_count !== 16'd2) begin bad++; $display("FAIL zz_blk_count: got %0d need 2", blk_count); end
   endtask

   task automatic test_dequant_sat();
      logic [767:0] b;
      q_write(0, 16);
      q_write(1, 255);
      q_write(8, 2);
      blk_q.delete();
      send(100, 1'b0);
      send(-2048, 1'b0);
      send(2047, 1'b1);
      wait_pulses(3);
      b = (blk_q.size() > 0) ? blk_q[0] : '0;
      total++;
      if (el(b, 0) != 1600) begin bad++; $display("FAIL dq_n0: got %0d need 1600", el(b, 0)); end
      total++;
      if (el(b, 1) != -2048) begin bad++; $display("FAIL dq_neg_sat: got %0d need -2048", el(b, 1)); end
      total++;
      if (el(b, 8) != 2047) begin bad++; $display("FAIL dq_pos_sat: got %0d need 2047", el(b, 8)); end
      total++;
      if (el(b, 16) != 0) begin bad++; $display("FAIL dq_zero_fill: got %0d need 0", el(b, 16)); end
      q_write(0, 1);
      q_write(1, 1);
      q_write(8, 1);
   endtask

   task automatic test_table_priority();
      logic [767:0] b;
      q_we = 1'b1; q_addr = 6'd0; q_data = 8'd4;
      s_valid = 1'b1; s_coef = 12'sd10; s_last = 1'b1;
      #1;
      total++;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL prio_ready: got %b need 0", s_ready); end
      @(negedge clk);
      q_we = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL prio_ready_after: got %b need 1", s_ready); end
      blk_q.delete();
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      s_valid = 1'b0; s_last = 1'b0;
      wait_pulses(4);
      b = (blk_q.size() > 0) ? blk_q[0] : '0;
      total++;
      if (el(b, 0) != 40) begin bad++; $display("FAIL prio_n0: got %0d need 40", el(b, 0)); end
      total++;
      if (b[767:12] !== '0) begin bad++; $display("FAIL prio_rest: got %h need 0", b[767:12]); end
      total++;
      if (pulse_cyc - acc_cyc != 1) begin
         bad++; $display("FAIL prio_latency: got %0d edges need 1", pulse_cyc - acc_cyc);
      end
      q_write(0, 1);
   endtask

   task automatic test_back_to_back();
      int e0 [64];
      int e1 [64];
      int e2 [64];
      logic [767:0] b;
      for (int k = 0; k < 64; k++) begin
         e0[zz[k]] = k + 1;
         e1[zz[k]] = 200 - k;
         e2[zz[k]] = (k < 10) ? -(k + 1) : 0;
      end
      blk_q.delete();
      for (int k = 0; k < 64; k++) send(k + 1, 1'b0);
      for (int k = 0; k < 64; k++) send(200 - k, 1'b0);
      for (int k = 0; k < 10; k++) begin
         idle($urandom_range(0, 2));
         send(-(k + 1), k == 9);
      end
      wait_pulses(7);
      for (int n = 0; n < 64; n++) begin
         b = (blk_q.size() > 0) ? blk_q[0] : '0;
         total++;
         if (el(b, n) != e0[n]) begin
            bad++; $display("FAIL b2b_blk0[%0d]: got %0d need %0d", n, el(b, n), e0[n]);
         end
         b = (blk_q.size() > 1) ? blk_q[1] : '0;
         total++;
         if (el(b, n) != e1[n]) begin
            bad++; $display("FAIL b2b_blk1[%0d]: got %0d need %0d", n, el(b, n), e1[n]);
         end
         b = (blk_q.size() > 2) ? blk_q[2] : '0;
         total++;
         if (el(b, n) != e2[n]) begin
            bad++; $display("FAIL b2b_blk2[%0d]: got %0d need %0d", n, el(b, n), e2[n]);
         end
      end
      total++;
      if (blk_count !== 16'd7) begin bad++; $display("FAIL b2b_blk_count: got %0d need 7", blk_count); end
   endtask

   task automatic test_reset_mid();
      int base;
      logic [767:0] b;
      for (int k = 0; k < 20; k++) send(7, 1'b0);
      base = pulses;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b need 0", out_valid); end
      end
      total++;
      if (blk_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count: got %0d need 0", blk_count); end
      rst = 1'b0;
      idle(3);
      total++;
      if (pulses != base) begin bad++; $display("FAIL mid_rst_stray: got %0d pulses need %0d", pulses, base); end
      blk_q.delete();
      send(5, 1'b1);
      wait_pulses(base + 1);
      b = (blk_q.size() > 0) ? blk_q[0] : '0;
      total++;
      if (el(b, 0) != 5) begin bad++; $display("FAIL mid_n0: got %0d need 5", el(b, 0)); end
      total++;
      if (b[767:12] !== '0) begin bad++; $display("FAIL mid_rest: got %h need 0", b[767:12]); end
      total++;
      if (blk_count !== 16'd1) begin bad++; $display("FAIL mid_blk_count: got %0d need 1", blk_count); end
   endtask

   initial begin
      test_reset();
      test_dc_eob();
      test_full_zigzag();
      test_dequant_sat();
      test_table_priority();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
